// File: rtl/face_pkg.sv
// Shared types and sizing for the face-detection path.
// Tile limits are common to the detection core and the overlay merger.
package face_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MERGE,
        DONE
    } state_t;

    localparam int MAX_TILE_DEF = 4096;
    localparam int ADDR_W_DEF   = 12;
    localparam int MARK_VAL_DEF = 255;

endpackage

// File: rtl/face_mask_buf.sv
// One-bit-per-pixel face mask storage for a single tile.
// Synchronous write, combinational read.
module face_mask_buf #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata
);

    logic mem [DEPTH];

    // store accepted mask bits; contents need no reset
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/face_overlay_merger.sv
// Overlays face-rectangle marks onto one tile's pixel stream.
// Loads the tile mask, then merges it with pixels into a 1-deep output reg.
module face_overlay_merger
    import face_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int MAX_TILE = MAX_TILE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MARK_VAL = MARK_VAL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   tile_len,
    input  logic              mask_valid,
    output logic              mask_ready,
    input  logic              mask_bit,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   mark_count
);

    localparam logic [ADDR_W:0]  ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]  MAX_LEN = MAX_TILE[ADDR_W:0];
    localparam logic [PIX_W-1:0] MARK    = MARK_VAL[PIX_W-1:0];

    state_t          state;
    state_t          state_n;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] last_idx;
    logic            len_ok;
    logic            start_ok;
    logic            mask_acc;
    logic            pix_acc;
    logic            out_hs;
    logic            buf_bit;

    assign last_idx = len - ONE;
    assign len_ok   = (tile_len != '0) && (tile_len <= MAX_LEN);
    assign start_ok = (state == IDLE) && start && len_ok;
    assign mask_acc = mask_valid && mask_ready;
    assign pix_acc  = pix_valid && pix_ready;
    assign out_hs   = out_valid && out_ready;

    face_mask_buf #(
        .DEPTH  (MAX_TILE),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .we    (mask_acc),
        .waddr (idx[ADDR_W-1:0]),
        .wdata (mask_bit),
        .raddr (idx[ADDR_W-1:0]),
        .rdata (buf_bit)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next state and handshake strobes
    always_comb begin
        state_n    = state;
        mask_ready = 1'b0;
        pix_ready  = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok)
                    state_n = LOAD;
            end
            LOAD: begin
                mask_ready = 1'b1;
                if (mask_valid && (idx == last_idx))
                    state_n = MERGE;
            end
            MERGE: begin
                pix_ready = (idx != len) && (!out_valid || out_ready);
                if (out_valid && out_ready && out_last)
                    state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // index, counters, error pulse and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            len        <= '0;
            idx        <= '0;
            mark_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= (state == IDLE) && start && !len_ok;
            if (start_ok) begin
                len        <= tile_len;
                idx        <= '0;
                mark_count <= '0;
                out_last   <= 1'b0;
            end
            if (mask_acc)
                idx <= (idx == last_idx) ? '0 : idx + ONE;
            if (pix_acc) begin
                out_data  <= buf_bit ? MARK : pix_data;
                out_last  <= (idx == last_idx);
                out_valid <= 1'b1;
                idx       <= idx + ONE;
                if (buf_bit)
                    mark_count <= mark_count + ONE;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
